// File: rtl/cast_xbar_pipe.sv
// Registered multicast crossbar: every input forks its flit to any subset of outputs,
// tracking delivered branches per input so each branch is written exactly once.
module cast_xbar_pipe #(
    parameter int PN = 5,
    parameter int DW = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [PN-1:0][PN-1:0]  xbar_sel_i,
    input  logic [PN-1:0][DW-1:0]  data_i,
    input  logic [PN-1:0]          valid_i,
    output logic [PN-1:0]          ready_o,
    output logic [PN-1:0][DW-1:0]  data_o,
    output logic [PN-1:0]          valid_o,
    input  logic [PN-1:0]          ready_i,
    output logic                   conflict_o,
    output logic [PN-1:0]          drop_o
);

    logic [PN-1:0][PN-1:0] done_q;
    logic [PN-1:0][PN-1:0] pend;
    logic [PN-1:0][PN-1:0] own;
    logic [PN-1:0][PN-1:0] deliver;
    logic [PN-1:0]         ld_ok;
    logic [PN-1:0]         taken;
    logic [PN-1:0]         load;
    logic [PN-1:0][DW-1:0] data_nxt;
    logic                  conflict_now;

    always_comb begin
        ld_ok        = ~valid_o | ready_i;
        own          = '0;
        taken        = '0;
        conflict_now = 1'b0;
        // Idle inputs may carry stale selects, so only valid inputs claim outputs.
        for (int j = 0; j < PN; j++) begin
            for (int i = 0; i < PN; i++) begin
                if (valid_i[i] && xbar_sel_i[i][j]) begin
                    if (taken[j]) begin
                        conflict_now = 1'b1;
                    end else begin
                        own[i][j] = 1'b1;
                        taken[j]  = 1'b1;
                    end
                end
            end
        end

        pend    = '0;
        deliver = '0;
        ready_o = '0;
        for (int i = 0; i < PN; i++) begin
            pend[i]    = xbar_sel_i[i] & ~done_q[i];
            deliver[i] = pend[i] & own[i] & ld_ok & {PN{valid_i[i]}};
            ready_o[i] = valid_i[i] & ~rst & ((pend[i] & ~deliver[i]) == '0);
        end

        // Ownership is unique per output, so OR-ing the delivering inputs is a clean mux.
        load     = '0;
        data_nxt = '0;
        for (int j = 0; j < PN; j++) begin
            for (int i = 0; i < PN; i++) begin
                if (deliver[i][j]) begin
                    load[j]     = 1'b1;
                    data_nxt[j] = data_nxt[j] | data_i[i];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o    <= '0;
            data_o     <= '0;
            done_q     <= '0;
            conflict_o <= 1'b0;
            drop_o     <= '0;
        end else begin
            conflict_o <= conflict_o | conflict_now;
            for (int i = 0; i < PN; i++) begin
                drop_o[i] <= valid_i[i] & (xbar_sel_i[i] == '0);
                done_q[i] <= ready_o[i] ? '0 : (done_q[i] | deliver[i]);
            end
            for (int j = 0; j < PN; j++) begin
                if (load[j]) begin
                    data_o[j]  <= data_nxt[j];
                    valid_o[j] <= 1'b1;
                end else if (ready_i[j]) begin
                    valid_o[j] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cast_xbar_pipe.sv
// Directed bench for cast_xbar_pipe: per-output expected-flit queues are filled when
// stimulus is driven and drained whenever an output handshake completes.
module tb_cast_xbar_pipe;

    localparam int PN = 5;
    localparam int DW = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [PN-1:0][PN-1:0] xbar_sel_i;
    logic [PN-1:0][DW-1:0] data_i;
    logic [PN-1:0]         valid_i;
    logic [PN-1:0]         ready_o;
    logic [PN-1:0][DW-1:0] data_o;
    logic [PN-1:0]         valid_o;
    logic [PN-1:0]         ready_i;
    logic                  conflict_o;
    logic [PN-1:0]         drop_o;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q [PN][$];

    cast_xbar_pipe #(.PN(PN), .DW(DW)) dut (
        .clk(clk), .rst(rst), .xbar_sel_i(xbar_sel_i), .data_i(data_i),
        .valid_i(valid_i), .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o),
        .ready_i(ready_i), .conflict_o(conflict_o), .drop_o(drop_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every completed output handshake must match the oldest expected flit for that port.
    task automatic monitor();
        logic [DW-1:0] e;
        for (int j = 0; j < PN; j++) begin
            if (!rst && valid_o[j] && ready_i[j]) begin
                n_cmp++;
                assert (exp_q[j].size() > 0) else begin
                    n_err++;
                    $error("FAIL out%0d_unexpected: observed=%0h expected=none", j, data_o[j]);
                end
                if (exp_q[j].size() > 0) begin
                    e = exp_q[j].pop_front();
                    chk($sformatf("out%0d_data", j), 64'(data_o[j]), 64'(e));
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i    = '0;
        xbar_sel_i = '0;
        data_i     = '0;
    endtask

    initial begin
        rst     = 1'b1;
        ready_i = '1;
        idle_inputs();
        step();
        step();
        chk("rst_valid_o", 64'(valid_o), 64'(0));
        chk("rst_data_o", 64'(data_o), 64'(0));
        chk("rst_conflict", 64'(conflict_o), 64'(0));
        chk("rst_drop", 64'(drop_o), 64'(0));
        rst = 1'b0;
        step();

        // Unicast in0 -> out2
        valid_i[0] = 1'b1; xbar_sel_i[0] = 5'b00100; data_i[0] = 32'hA5;
        #1 chk("uni_ready0", 64'(ready_o[0]), 64'(1));
        exp_q[2].push_back(32'hA5);
        step();
        chk("uni_valid2", 64'(valid_o), 64'(5'b00100));
        chk("uni_data2", 64'(data_o[2]), 64'hA5);
        idle_inputs();
        step();

        // Fork in1 -> {0,1,4} with out4 occupied and stalled
        ready_i = 5'b01111;
        valid_i[2] = 1'b1; xbar_sel_i[2] = 5'b10000; data_i[2] = 32'h44;
        exp_q[4].push_back(32'h44);
        step();
        idle_inputs();
        valid_i[1] = 1'b1; xbar_sel_i[1] = 5'b10011; data_i[1] = 32'h11;
        for (int c = 0; c < 3; c++) begin
            #1 chk($sformatf("fork_stall_ready1_c%0d", c), 64'(ready_o[1]), 64'(0));
            if (c == 0) begin
                exp_q[0].push_back(32'h11);
                exp_q[1].push_back(32'h11);
            end
            step();
        end
        chk("fork_hold4", 64'(data_o[4]), 64'h44);
        ready_i = '1;
        #1 chk("fork_release_ready1", 64'(ready_o[1]), 64'(1));
        exp_q[4].push_back(32'h11);
        step();
        chk("fork_out4", 64'(data_o[4]), 64'h11);
        idle_inputs();
        step();
        step();

        // Streaming in3 -> out1
        for (int k = 0; k < 10; k++) begin
            valid_i[3] = 1'b1; xbar_sel_i[3] = 5'b00010; data_i[3] = 32'(k);
            #1 chk($sformatf("stream_ready3_%0d", k), 64'(ready_o[3]), 64'(1));
            exp_q[1].push_back(32'(k));
            step();
            chk($sformatf("stream_out1_%0d", k), 64'({valid_o[1], data_o[1]}), 64'({1'b1, 32'(k)}));
        end
        idle_inputs();
        step();
        step();

        // Backpressure on out2
        ready_i = 5'b11011;
        valid_i[0] = 1'b1; xbar_sel_i[0] = 5'b00100; data_i[0] = 32'hB0;
        exp_q[2].push_back(32'hB0);
        step();
        data_i[0] = 32'hB1;
        for (int c = 0; c < 2; c++) begin
            #1 chk($sformatf("bp_ready0_c%0d", c), 64'(ready_o[0]), 64'(0));
            step();
            chk($sformatf("bp_hold2_c%0d", c), 64'({valid_o[2], data_o[2]}), 64'({1'b1, 32'hB0}));
        end
        ready_i = '1;
        #1 chk("bp_release_ready0", 64'(ready_o[0]), 64'(1));
        exp_q[2].push_back(32'hB1);
        step();
        chk("bp_out2_new", 64'(data_o[2]), 64'hB1);
        idle_inputs();
        step();
        step();

        // Conflict on out3: in0 wins, flag is sticky
        valid_i[0] = 1'b1; xbar_sel_i[0] = 5'b01000; data_i[0] = 32'hC0;
        valid_i[4] = 1'b1; xbar_sel_i[4] = 5'b01000; data_i[4] = 32'hC4;
        #1 chk("cf_ready", 64'({ready_o[4], ready_o[0]}), 64'(2'b01));
        exp_q[3].push_back(32'hC0);
        step();
        chk("cf_flag", 64'(conflict_o), 64'(1));
        chk("cf_out3", 64'(data_o[3]), 64'hC0);
        idle_inputs();
        step();
        chk("cf_sticky", 64'(conflict_o), 64'(1));

        // Empty selection is consumed and discarded
        valid_i[2] = 1'b1; data_i[2] = 32'hDD;
        #1 chk("drop_ready2", 64'(ready_o[2]), 64'(1));
        step();
        chk("drop_pulse", 64'(drop_o), 64'(5'b00100));
        chk("drop_no_out", 64'(valid_o), 64'(0));
        idle_inputs();
        step();
        chk("drop_pulse_end", 64'(drop_o), 64'(0));

        // Reset during a stalled fork, then the same flit re-sent
        ready_i = 5'b01111;
        valid_i[2] = 1'b1; xbar_sel_i[2] = 5'b10000; data_i[2] = 32'h44;
        step();
        idle_inputs();
        valid_i[1] = 1'b1; xbar_sel_i[1] = 5'b10011; data_i[1] = 32'h22;
        exp_q[0].push_back(32'h22);
        exp_q[1].push_back(32'h22);
        step();
        step();
        rst = 1'b1;
        for (int j = 0; j < PN; j++) exp_q[j].delete();
        step();
        chk("rr_valid_o", 64'(valid_o), 64'(0));
        chk("rr_conflict", 64'(conflict_o), 64'(0));
        rst = 1'b0;
        ready_i = '1;
        #1 chk("rr_ready1", 64'(ready_o[1]), 64'(1));
        exp_q[0].push_back(32'h22);
        exp_q[1].push_back(32'h22);
        exp_q[4].push_back(32'h22);
        step();
        chk("rr_resend_valid", 64'(valid_o), 64'(5'b10011));
        idle_inputs();
        step();
        step();

        for (int j = 0; j < PN; j++)
            chk($sformatf("q%0d_drained", j), 64'(exp_q[j].size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
